// File: rtl/rtl_handshake_pkg.sv
// Shared types and helpers for the handshake transmitter.
//   W          : default operand width
//   req_t      : buffered operand pair {in1, in2}
//   reduce_out : result bit presented alongside each pair
package rtl_handshake_pkg;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] in1;
        logic [W-1:0] in2;
    } req_t;

    // True only when every bit of v is set (and at least one bit is set).
    function automatic logic reduce_out(input logic [W-1:0] v);
        return (|v) && (&v);
    endfunction

endpackage

// File: rtl/rtl_handshake_fifo.sv
// Synchronous FIFO for operand pairs.
//   clk, rst   : clock, synchronous active-high reset
//   push_i     : write wr_data_i (ignored while full)
//   pop_i      : advance the head (ignored while empty)
//   rd_data_o  : current head entry
//   count_o    : registered occupancy
//   empty_o    : occupancy is zero
//   full_o     : occupancy equals DEPTH
module rtl_handshake_fifo
    import rtl_handshake_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = req_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  T                       wr_data_i,
    input  logic                   pop_i,
    output T                       rd_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    T                   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push_ok;
    logic               pop_ok;

    assign empty_o   = (count_q == CNT_W'(0));
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign push_ok   = push_i && !full_o;
    assign pop_ok    = pop_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Pointers wrap naturally; occupancy tracked separately.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible behind valid pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/rtl_handshake_tx.sv
// Ready/valid transmitter: buffers operand pairs and presents each with its
// reduction result from a single registered output slot.
//   CLK, RESET               : clock, synchronous active-high reset
//   req_valid/req_ready      : upstream operand-pair handshake
//   req_in1, req_in2         : incoming operands
//   handshake_valid/_ready   : downstream result handshake
//   in1, in2, out            : presented pair and its reduction result
//   count                    : FIFO occupancy (output slot excluded)
//   tx_count                 : completed downstream transfers, mod 2^16
module rtl_handshake_tx #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [W-1:0]           req_in1,
    input  logic [W-1:0]           req_in2,
    output logic                   handshake_valid,
    input  logic                   handshake_ready,
    output logic [W-1:0]           in1,
    output logic [W-1:0]           in2,
    output logic                   out,
    output logic [$clog2(DEPTH):0] count,
    output logic [15:0]            tx_count
);

    import rtl_handshake_pkg::*;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    state_e        state_q;
    logic [W-1:0]  in1_q;
    logic [W-1:0]  in2_q;
    logic          out_q;
    logic [15:0]   tx_count_q;

    req_t          push_data;
    req_t          head;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          xfer;

    // req_ready depends only on the registered occupancy.
    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;
    assign push_data = '{in1: req_in1, in2: req_in2};
    assign xfer      = (state_q == S_FULL) && handshake_ready;
    // Refill the slot whenever it is empty or being drained this cycle.
    assign pop       = !fifo_empty && ((state_q == S_EMPTY) || handshake_ready);

    rtl_handshake_fifo #(
        .DEPTH (DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push_i    (push),
        .wr_data_i (push_data),
        .pop_i     (pop),
        .rd_data_o (head),
        .count_o   (count),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    // Output slot FSM; the result bit is computed once at load time.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_EMPTY;
            in1_q      <= '0;
            in2_q      <= '0;
            out_q      <= 1'b0;
            tx_count_q <= '0;
        end else begin
            if (xfer) tx_count_q <= tx_count_q + 16'd1;
            if (pop) begin
                state_q <= S_FULL;
                in1_q   <= head.in1;
                in2_q   <= head.in2;
                out_q   <= reduce_out(head.in1);
            end else if (xfer) begin
                state_q <= S_EMPTY;
            end
        end
    end

    assign handshake_valid = (state_q == S_FULL);
    assign in1             = in1_q;
    assign in2             = in2_q;
    assign out             = out_q;
    assign tx_count        = tx_count_q;

endmodule

// File: tb/tb_rtl_handshake_tx.sv
// Self-checking bench for rtl_handshake_tx.
module tb_rtl_handshake_tx;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_in1;
    logic [3:0]  req_in2;
    logic        handshake_valid;
    logic        handshake_ready;
    logic [3:0]  in1;
    logic [3:0]  in2;
    logic        out;
    logic [2:0]  count;
    logic [15:0] tx_count;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    rtl_handshake_tx #(.DEPTH(4), .W(4)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_in1         (req_in1),
        .req_in2         (req_in2),
        .handshake_valid (handshake_valid),
        .handshake_ready (handshake_ready),
        .in1             (in1),
        .in2             (in2),
        .out             (out),
        .count           (count),
        .tx_count        (tx_count)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [3:0]  a;
        logic [3:0]  b;
        logic        rdy;
        logic        e_hv;
        logic [3:0]  e_in1;
        logic [3:0]  e_in2;
        logic        e_out;
        logic [2:0]  e_cnt;
        logic        e_rreq;
        logic [15:0] e_tx;
        logic        chk_data;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [3:0]  bp_a [5];
        logic [3:0]  bp_b [5];
        logic        bp_o [5];
        logic [7:0]  sb [$];
        logic [7:0]  e;
        logic [8:0]  snap;
        logic        do_push;
        logic        do_xfer;
        logic        stall;
        int          accepted;
        int          sent;
        int          recv;
        int          cyc;
        int          n;

        RESET = 1'b1; req_valid = 1'b0; req_in1 = '0; req_in2 = '0; handshake_ready = 1'b0;

        // inputs applied before the edge; expected values observed after it
        vecs[0] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 1'b1, 16'd0, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 4'hF, 4'h3, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 3'd1, 1'b1, 16'd0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'hF, 4'h3, 1'b1, 3'd0, 1'b1, 16'd0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 1'b1, 16'd1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 4'h0, 4'h1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 3'd1, 1'b1, 16'd1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 4'h7, 4'h2, 1'b1, 1'b1, 4'h0, 4'h1, 1'b0, 3'd1, 1'b1, 16'd1, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 4'hF, 4'h3, 1'b1, 1'b1, 4'h7, 4'h2, 1'b0, 3'd1, 1'b1, 16'd2, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 4'h8, 4'h4, 1'b1, 1'b1, 4'hF, 4'h3, 1'b1, 3'd1, 1'b1, 16'd3, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h8, 4'h4, 1'b0, 3'd0, 1'b1, 16'd4, 1'b1};
        vecs[9] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 1'b1, 16'd5, 1'b0};

        for (int i = 0; i < 10; i++) begin
            RESET = vecs[i].rst; req_valid = vecs[i].vld; req_in1 = vecs[i].a;
            req_in2 = vecs[i].b; handshake_ready = vecs[i].rdy;
            tick();
            check($sformatf("v%0d_hv", i), 32'(handshake_valid), 32'(vecs[i].e_hv));
            check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            check($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_rreq));
            check($sformatf("v%0d_tx_count", i), 32'(tx_count), 32'(vecs[i].e_tx));
            if (vecs[i].chk_data) begin
                check($sformatf("v%0d_data", i), 32'({in1, in2, out}),
                      32'({vecs[i].e_in1, vecs[i].e_in2, vecs[i].e_out}));
            end
        end
        req_valid = 1'b0;

        // backpressure: five pairs fill slot + FIFO, sixth stalls
        bp_a = '{4'hF, 4'h1, 4'hE, 4'hF, 4'h7};
        bp_b = '{4'h2, 4'h4, 4'h6, 4'h8, 4'hA};
        bp_o = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        handshake_ready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 8; c++) begin
            req_valid = 1'b1;
            req_in1 = (accepted < 5) ? bp_a[accepted] : 4'h3;
            req_in2 = (accepted < 5) ? bp_b[accepted] : 4'h3;
            do_push = req_ready;
            tick();
            if (do_push) accepted++;
            if (c >= 1) check($sformatf("bp_hold%0d", c), 32'({handshake_valid, in1, in2, out}),
                              32'({1'b1, bp_a[0], bp_b[0], bp_o[0]}));
        end
        check("bp_accepted", 32'(accepted), 32'd5);
        check("bp_count", 32'(count), 32'd4);
        check("bp_req_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        handshake_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_drain%0d", k), 32'({handshake_valid, in1, in2, out}),
                  32'({1'b1, bp_a[k], bp_b[k], bp_o[k]}));
            tick();
        end
        check("bp_after_hv", 32'(handshake_valid), 32'd0);
        check("bp_after_tx", 32'(tx_count), 32'd10);
        check("bp_after_count", 32'(count), 32'd0);

        // random traffic with a scoreboard
        RESET = 1'b1; tick(); RESET = 1'b0;
        sent = 0; recv = 0; cyc = 0;
        while (recv < 1000 && cyc < 20000) begin
            req_valid = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_in1 = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            req_in2 = 4'($urandom);
            handshake_ready = 1'($urandom_range(0, 1));
            do_push = req_valid && req_ready;
            do_xfer = handshake_valid && handshake_ready;
            stall = handshake_valid && !handshake_ready;
            snap = {in1, in2, out};
            if (do_xfer) begin
                if (sb.size() == 0) begin
                    check("rnd_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rnd_data", 32'({in1, in2, out}), 32'({e, (|e[7:4]) && (&e[7:4])}));
                end
            end
            if (do_push) begin
                sb.push_back({req_in1, req_in2});
                sent++;
            end
            tick();
            cyc++;
            if (stall) check("rnd_stable", 32'({handshake_valid, in1, in2, out}), 32'({1'b1, snap}));
            if (do_xfer) recv++;
        end
        check("rnd_done", 32'(recv), 32'd1000);
        check("rnd_tx_count", 32'(tx_count), 32'd1000);

        // reset with three entries buffered and the slot full
        req_valid = 1'b0; handshake_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_in1 = 4'(k + 10); req_in2 = 4'(k + 1);
            tick();
        end
        req_valid = 1'b0;
        check("rst_pre_count", 32'(count), 32'd3);
        check("rst_pre_hv", 32'(handshake_valid), 32'd1);
        RESET = 1'b1; handshake_ready = 1'b1;
        tick();
        RESET = 1'b0;
        check("rst_state", 32'({handshake_valid, count, tx_count, in1, in2, out, req_ready}),
              32'({1'b0, 3'd0, 16'd0, 4'h0, 4'h0, 1'b0, 1'b1}));
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rst_nostale%0d", k), 32'({handshake_valid, tx_count}), 32'd0);
        end
        req_valid = 1'b1; req_in1 = 4'h6; req_in2 = 4'h9;
        tick();
        req_valid = 1'b0;
        tick();
        check("rst_fresh", 32'({handshake_valid, in1, in2, out}), 32'({1'b1, 4'h6, 4'h9, 1'b0}));
        tick();
        check("rst_fresh_done", 32'({handshake_valid, tx_count}), 32'({1'b0, 16'd1}));

        // tx_count wrap after 65536 transfers
        RESET = 1'b1; tick(); RESET = 1'b0;
        handshake_ready = 1'b1; req_valid = 1'b1; req_in1 = 4'hF; req_in2 = 4'h0;
        n = 0; cyc = 0;
        while (n < 65536 && cyc < 70000) begin
            do_xfer = handshake_valid && handshake_ready;
            tick();
            cyc++;
            if (do_xfer) begin
                n++;
                if (n == 65535) check("wrap_ffff", 32'(tx_count), 32'hFFFF);
                if (n == 65536) check("wrap_zero", 32'(tx_count), 32'h0);
            end
        end
        check("wrap_done", 32'(n), 32'd65536);
        req_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
